// File: rtl/icache_axi_read_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_axi_read_bridge_pkg
// Description : Shared instruction-cache definitions. Holds the bridge state
//               encoding, AXI constants and the line-offset width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package icache_axi_read_bridge_pkg;

  // Bridge transaction phases
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_RET  = 2'd3
  } bridge_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Byte-offset width of one cache line. The cache uses the same helper, so
  // both sides always agree on line alignment.
  function automatic int line_off_width(input int line_word_num);
    return $clog2(4 * line_word_num);
  endfunction

endpackage
`default_nettype wire

// File: rtl/icache_axi_read_bridge_line_assembler.sv
`default_nettype none
// ============================================================================
// Module      : line_assembler
// Description : Collects 32-bit read beats into a cache-line-wide register.
//               The beat counter saturates on the last slot, so surplus beats
//               overwrite that slot. Slots not written keep old contents.
// Revision    : 1.0 - initial release
// ============================================================================
module line_assembler #(
  parameter int LINE_WORD_NUM = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       clear,
  input  logic                       beat_valid,
  input  logic [31:0]                beat_data,
  output logic [32*LINE_WORD_NUM-1:0] line_data
);

  localparam int CNT_W = (LINE_WORD_NUM > 1) ? $clog2(LINE_WORD_NUM) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LINE_WORD_NUM - 1);

  logic [CNT_W-1:0] cnt;

  // Beat counter: restart per transaction, saturate at the last slot
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (beat_valid && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < LINE_WORD_NUM; i++) begin : g_slot
    logic [31:0] slot_q;

    // Slot register: capture the beat addressed by the counter
    always_ff @(posedge clk) begin
      if (!resetn) begin
        slot_q <= '0;
      end else if (beat_valid && (cnt == CNT_W'(i))) begin
        slot_q <= beat_data;
      end
    end

    assign line_data[32*i +: 32] = slot_q;
  end

endmodule
`default_nettype wire

// File: rtl/icache_axi_read_bridge.sv
`default_nettype none
// ============================================================================
// Module      : icache_axi_read_bridge
// Description : Read-only AXI4 master for the instruction cache. Turns one
//               line refill or uncached word read into a single INCR burst,
//               one transaction outstanding at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_axi_read_bridge
  import icache_axi_read_bridge_pkg::*;
#(
  parameter int                  LINE_WORD_NUM = 4,
  parameter int                  ID_WIDTH      = 4,
  parameter logic [ID_WIDTH-1:0] AXI_ID        = '0
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        line_rd_req,
  input  logic [31:0]                 line_rd_addr,
  output logic                        line_rd_rdy,
  output logic                        line_ret_valid,
  output logic [32*LINE_WORD_NUM-1:0] line_ret_data,
  input  logic                        unc_rd_req,
  input  logic [31:0]                 unc_rd_addr,
  output logic                        unc_rd_rdy,
  output logic                        unc_ret_valid,
  output logic [31:0]                 unc_ret_data,
  output logic                        bus_err,
  output logic [ID_WIDTH-1:0]         arid,
  output logic [31:0]                 araddr,
  output logic [7:0]                  arlen,
  output logic [2:0]                  arsize,
  output logic [1:0]                  arburst,
  output logic                        arvalid,
  input  logic                        arready,
  input  logic [ID_WIDTH-1:0]         rid,
  input  logic [31:0]                 rdata,
  input  logic [1:0]                  rresp,
  input  logic                        rlast,
  input  logic                        rvalid,
  output logic                        rready
);

  localparam int          OFF       = line_off_width(LINE_WORD_NUM);
  localparam logic [31:0] LINE_MASK = ~((32'd1 << OFF) - 32'd1);
  localparam logic [7:0]  LINE_LEN  = 8'(LINE_WORD_NUM - 1);

  bridge_state_t state, state_n;
  logic          is_line, is_line_n;
  logic          err, err_n;
  logic          accept;
  logic          beat;
  logic          unused_inputs;

  // rid is not checked and only rresp[1] distinguishes an error response
  assign unused_inputs = ^{rid, rresp[0]};

  // Acceptance is a pure decode of IDLE and the request lines; line wins
  assign line_rd_rdy = (state == S_IDLE) && line_rd_req;
  assign unc_rd_rdy  = (state == S_IDLE) && unc_rd_req && !line_rd_req;
  assign accept      = line_rd_rdy || unc_rd_rdy;
  assign beat        = (state == S_R) && rvalid;

  assign arid    = AXI_ID;
  assign arsize  = AXI_SIZE_4B;
  assign arburst = AXI_BURST_INCR;

  // Next-state, request kind and sticky error flag
  always_comb begin
    state_n   = state;
    is_line_n = is_line;
    err_n     = err;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_n   = S_AR;
          is_line_n = line_rd_rdy;
          err_n     = 1'b0;
        end
      end
      S_AR: begin
        if (arready) state_n = S_R;
      end
      S_R: begin
        if (rvalid) begin
          if (rresp[1]) err_n = 1'b1;
          if (rlast)    state_n = S_RET;
        end
      end
      S_RET: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State register and registered control outputs derived from next state
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= S_IDLE;
      is_line        <= 1'b0;
      err            <= 1'b0;
      arvalid        <= 1'b0;
      rready         <= 1'b0;
      line_ret_valid <= 1'b0;
      unc_ret_valid  <= 1'b0;
      bus_err        <= 1'b0;
    end else begin
      state          <= state_n;
      is_line        <= is_line_n;
      err            <= err_n;
      arvalid        <= (state_n == S_AR);
      rready         <= (state_n == S_R);
      line_ret_valid <= (state_n == S_RET) && is_line_n;
      unc_ret_valid  <= (state_n == S_RET) && !is_line_n;
      bus_err        <= (state_n == S_RET) && err_n;
    end
  end

  // AR fields are captured at acceptance so they stay stable while stalled
  always_ff @(posedge clk) begin
    if (!resetn) begin
      araddr       <= '0;
      arlen        <= '0;
      unc_ret_data <= '0;
    end else begin
      if (accept) begin
        araddr <= line_rd_rdy ? (line_rd_addr & LINE_MASK)
                              : {unc_rd_addr[31:2], 2'b00};
        arlen  <= line_rd_rdy ? LINE_LEN : 8'd0;
      end
      if (beat && !is_line) begin
        unc_ret_data <= rdata;
      end
    end
  end

  line_assembler #(
    .LINE_WORD_NUM (LINE_WORD_NUM)
  ) u_line_assembler (
    .clk        (clk),
    .resetn     (resetn),
    .clear      (accept),
    .beat_valid (beat && is_line),
    .beat_data  (rdata),
    .line_data  (line_ret_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_icache_axi_read_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_axi_read_bridge
// Description : Self-checking bench for icache_axi_read_bridge. Expected
//               returns are queued at request acceptance and compared when
//               the bridge pulses a ret_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_axi_read_bridge;
  import icache_axi_read_bridge_pkg::*;

  localparam int LWN = 4;
  localparam int DW  = 32 * LWN;

  logic          clk = 1'b0;
  logic          resetn;
  logic          line_rd_req;
  logic [31:0]   line_rd_addr;
  logic          line_rd_rdy;
  logic          line_ret_valid;
  logic [DW-1:0] line_ret_data;
  logic          unc_rd_req;
  logic [31:0]   unc_rd_addr;
  logic          unc_rd_rdy;
  logic          unc_ret_valid;
  logic [31:0]   unc_ret_data;
  logic          bus_err;
  logic [3:0]    arid;
  logic [31:0]   araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid;
  logic          arready;
  logic [3:0]    rid;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready;

  icache_axi_read_bridge #(
    .LINE_WORD_NUM (LWN),
    .ID_WIDTH      (4),
    .AXI_ID        (4'h0)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .line_rd_req    (line_rd_req),
    .line_rd_addr   (line_rd_addr),
    .line_rd_rdy    (line_rd_rdy),
    .line_ret_valid (line_ret_valid),
    .line_ret_data  (line_ret_data),
    .unc_rd_req     (unc_rd_req),
    .unc_rd_addr    (unc_rd_addr),
    .unc_rd_rdy     (unc_rd_rdy),
    .unc_ret_valid  (unc_ret_valid),
    .unc_ret_data   (unc_ret_data),
    .bus_err        (bus_err),
    .arid           (arid),
    .araddr         (araddr),
    .arlen          (arlen),
    .arsize         (arsize),
    .arburst        (arburst),
    .arvalid        (arvalid),
    .arready        (arready),
    .rid            (rid),
    .rdata          (rdata),
    .rresp          (rresp),
    .rlast          (rlast),
    .rvalid         (rvalid),
    .rready         (rready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          is_line;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   pass_count  = 0;
  int   check_count = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    check_count++;
    if (obs === exp) pass_count++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one R beat for one cycle; rready must be high while in R
  task automatic beat(input logic [31:0] d, input logic [1:0] resp, input logic last);
    rvalid = 1'b1;
    rdata  = d;
    rresp  = resp;
    rlast  = last;
    @(negedge clk);
    check("rready_in_r", DW'(rready), DW'(1));
    step();
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
  endtask

  // Line request presented for one cycle; rdy must pulse in that cycle
  task automatic line_req(input logic [31:0] addr);
    line_rd_req  = 1'b1;
    line_rd_addr = addr;
    @(negedge clk);
    check("line_rdy", DW'(line_rd_rdy), DW'(1));
    check("unc_rdy_idle", DW'(unc_rd_rdy), DW'(0));
    step();
    line_rd_req = 1'b0;
  endtask

  // Accept AR immediately and check the address phase fields
  task automatic ar_accept(input logic [31:0] exp_addr, input logic [7:0] exp_len);
    arready = 1'b1;
    @(negedge clk);
    check("arvalid", DW'(arvalid), DW'(1));
    check("araddr", DW'(araddr), DW'(exp_addr));
    check("arlen", DW'(arlen), DW'(exp_len));
    check("arsize_burst_id", DW'({arsize, arburst, arid}), DW'({3'b010, 2'b01, 4'h0}));
    check("rready_in_ar", DW'(rready), DW'(0));
    step();
    arready = 1'b0;
  endtask

  // Scoreboard side: every returned transaction is matched in order
  always @(negedge clk) begin
    if (resetn && (line_ret_valid || unc_ret_valid)) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_ret", DW'(1), DW'(0));
      end else begin
        mon_e = sb.pop_front();
        check("ret_kind", DW'(line_ret_valid), DW'(mon_e.is_line));
        check("ret_data", mon_e.is_line ? line_ret_data : DW'(unc_ret_data), mon_e.data);
        check("ret_bus_err", DW'(bus_err), DW'(mon_e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn       = 1'b0;
    line_rd_req  = 1'b0;
    line_rd_addr = '0;
    unc_rd_req   = 1'b0;
    unc_rd_addr  = '0;
    arready      = 1'b0;
    rid          = '0;
    rdata        = '0;
    rresp        = 2'b00;
    rlast        = 1'b0;
    rvalid       = 1'b0;
    step();
    step();
    @(negedge clk);
    check("rst_ctrl", DW'({arvalid, rready, line_rd_rdy, unc_rd_rdy, line_ret_valid, unc_ret_valid, bus_err}), DW'(0));
    check("rst_line_data", line_ret_data, DW'(0));
    check("rst_unc_data", DW'(unc_ret_data), DW'(0));
    step();
    resetn = 1'b1;

    // Basic line refill, beats back to back
    step();
    sb.push_back(exp_t'{1'b1, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b0});
    line_req(32'h1FC0_0014);
    ar_accept(32'h1FC0_0010, 8'd3);
    beat(32'hA0, 2'b00, 1'b0);
    beat(32'hA1, 2'b00, 1'b0);
    beat(32'hA2, 2'b00, 1'b0);
    beat(32'hA3, 2'b00, 1'b1);
    @(negedge clk);
    check("line_ret_latency", DW'({line_ret_valid, bus_err}), DW'(2'b10));
    step();
    @(negedge clk);
    check("line_ret_one_pulse", DW'(line_ret_valid), DW'(0));

    // Uncached read with AR stalled three cycles
    step();
    unc_rd_req  = 1'b1;
    unc_rd_addr = 32'hBFD0_0003;
    @(negedge clk);
    check("unc_rdy", DW'({unc_rd_rdy, line_rd_rdy}), DW'(2'b10));
    sb.push_back(exp_t'{1'b0, DW'(32'hDEADBEEF), 1'b0});
    step();
    unc_rd_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("ar_stall_stable", DW'({arvalid, araddr, arlen}), DW'({1'b1, 32'hBFD0_0000, 8'd0}));
      step();
    end
    // Beat presented in the AR acceptance cycle must be ignored
    rvalid = 1'b1;
    rlast  = 1'b1;
    rdata  = 32'h1234_5678;
    ar_accept(32'hBFD0_0000, 8'd0);
    beat(32'hDEADBEEF, 2'b00, 1'b1);
    @(negedge clk);
    check("unc_ret_valid", DW'({unc_ret_valid, line_ret_valid}), DW'(2'b10));

    // Both requests together: line first, uncached right after RET
    step();
    line_rd_req  = 1'b1;
    line_rd_addr = 32'h0000_1000;
    unc_rd_req   = 1'b1;
    unc_rd_addr  = 32'h0000_2004;
    @(negedge clk);
    check("prio_rdy", DW'({line_rd_rdy, unc_rd_rdy}), DW'(2'b10));
    sb.push_back(exp_t'{1'b1, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 1'b0});
    step();
    line_rd_req = 1'b0;
    ar_accept(32'h0000_1000, 8'd3);
    beat(32'hB0, 2'b00, 1'b0);
    beat(32'hB1, 2'b00, 1'b0);
    beat(32'hB2, 2'b00, 1'b0);
    beat(32'hB3, 2'b00, 1'b1);
    @(negedge clk);
    check("unc_rdy_in_ret", DW'({line_ret_valid, unc_rd_rdy}), DW'(2'b10));
    step();
    @(negedge clk);
    check("unc_rdy_after_ret", DW'(unc_rd_rdy), DW'(1));
    sb.push_back(exp_t'{1'b0, DW'(32'hC0DE_0001), 1'b0});
    step();
    unc_rd_req = 1'b0;
    ar_accept(32'h0000_2004, 8'd0);
    beat(32'hC0DE_0001, 2'b00, 1'b1);
    @(negedge clk);
    check("pending_unc_ret", DW'(unc_ret_valid), DW'(1));

    // Line refill with rvalid gaps and SLVERR on the third beat
    step();
    sb.push_back(exp_t'{1'b1, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 1'b1});
    line_req(32'h0000_3008);
    ar_accept(32'h0000_3000, 8'd3);
    beat(32'hD0, 2'b00, 1'b0);
    step();
    beat(32'hD1, 2'b00, 1'b0);
    step();
    step();
    beat(32'hD2, 2'b10, 1'b0);
    beat(32'hD3, 2'b00, 1'b1);
    @(negedge clk);
    check("gap_err_ret", DW'({line_ret_valid, bus_err}), DW'(2'b11));
    step();
    @(negedge clk);
    check("bus_err_one_pulse", DW'(bus_err), DW'(0));

    // Reset mid-burst after the second beat
    step();
    line_req(32'h0000_4000);
    ar_accept(32'h0000_4000, 8'd3);
    beat(32'hE0, 2'b00, 1'b0);
    beat(32'hE1, 2'b00, 1'b0);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    @(negedge clk);
    check("mid_rst_ctrl", DW'({arvalid, rready, line_rd_rdy, unc_rd_rdy, line_ret_valid, unc_ret_valid, bus_err}), DW'(0));
    check("mid_rst_state", DW'(dut.state), DW'(S_IDLE));
    check("mid_rst_line_data", line_ret_data, DW'(0));
    check("mid_rst_unc_data", DW'(unc_ret_data), DW'(0));
    step();
    sb.push_back(exp_t'{1'b1, {32'hF3, 32'hF2, 32'hF1, 32'hF0}, 1'b0});
    line_req(32'h0000_4040);
    ar_accept(32'h0000_4040, 8'd3);
    beat(32'hF0, 2'b00, 1'b0);
    beat(32'hF1, 2'b00, 1'b0);
    beat(32'hF2, 2'b00, 1'b0);
    beat(32'hF3, 2'b00, 1'b1);
    @(negedge clk);
    check("post_rst_ret", DW'(line_ret_valid), DW'(1));

    // Early rlast: slots 2-3 keep the previous line's words
    step();
    sb.push_back(exp_t'{1'b1, {32'hF3, 32'hF2, 32'h22, 32'h11}, 1'b0});
    line_req(32'h0000_5000);
    ar_accept(32'h0000_5000, 8'd3);
    beat(32'h11, 2'b00, 1'b0);
    beat(32'h22, 2'b00, 1'b1);
    @(negedge clk);
    check("early_rlast_ret", DW'(line_ret_valid), DW'(1));

    step();
    step();
    @(negedge clk);
    check("sb_drain", DW'(sb.size()), DW'(0));
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
`default_nettype wire
